// File: rtl/ioq_dispatch_reader.sv
// Dequeue side of the in-order instruction queue: pulls entries through a 2-deep buffer and
// dispatches the head to its functional unit. Unit lanes are MSB-first: unit code i uses bit [numUnits-1-i].
module ioq_dispatch_reader #(
    parameter int                    entryWidth       = 299,
    parameter int                    funcUnitCodeSize = 3,
    parameter int                    numUnits         = 8,
    parameter logic [numUnits-1:0]   validUnitMask    = 8'b11111010,
    parameter int                    counterWidth     = 32
) (
    input  logic                        clock_i,
    input  logic                        reset_i,
    input  logic                        isEmpty_i,
    input  logic [funcUnitCodeSize-1:0] funcUnitType_i,
    input  logic [entryWidth-1:0]       entry_i,
    output logic                        readEnable_o,
    input  logic                        flush_i,
    input  logic [numUnits-1:0]         unitReady_i,
    output logic [numUnits-1:0]         dispatchValid_o,
    output logic [entryWidth-1:0]       dispatchEntry_o,
    output logic [funcUnitCodeSize-1:0] dispatchFU_o,
    output logic [1:0]                  occupancy_o,
    output logic                        badUnit_o,
    output logic [counterWidth-1:0]     dispatchCount_o,
    output logic [counterWidth-1:0]     stallCount_o
);

    logic [entryWidth-1:0]       buf_entry [2];
    logic [funcUnitCodeSize-1:0] buf_fu    [2];
    logic                        head_ptr;
    logic                        tail_ptr;
    logic [1:0]                  occ;
    logic                        inflight;

    logic                        head_valid;
    logic [funcUnitCodeSize-1:0] head_fu;
    logic [numUnits-1:0]         head_onehot;
    logic                        fu_valid;
    logic                        unit_ready;
    logic                        pop;
    logic                        transfer;
    logic                        stall;
    logic [2:0]                  fill_next;

    assign head_valid = (occ != 2'd0);
    assign head_fu    = buf_fu[head_ptr];

    always_comb begin
        head_onehot = '0;
        for (int i = 0; i < numUnits; i++) begin
            head_onehot[numUnits-1-i] = (int'(head_fu) == i);
        end
    end

    assign fu_valid   = |(head_onehot & validUnitMask);
    assign unit_ready = |(head_onehot & unitReady_i);

    // Invalid unit codes drain in one cycle so a bad entry can never wedge the buffer.
    assign pop   = head_valid && !flush_i && (unit_ready || !fu_valid);
    assign stall = head_valid && !flush_i && fu_valid && !unit_ready;

    // Entries already held or in flight, after this cycle's pop, must leave room for one more.
    assign fill_next    = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign readEnable_o = !reset_i && !isEmpty_i && !flush_i && (fill_next < 3'd2);

    assign dispatchValid_o = (head_valid && fu_valid && !flush_i && !reset_i) ? head_onehot : '0;
    assign transfer        = |(dispatchValid_o & unitReady_i);
    assign dispatchEntry_o = buf_entry[head_ptr];
    assign dispatchFU_o    = head_fu;
    assign occupancy_o     = occ;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            occ             <= 2'd0;
            inflight        <= 1'b0;
            head_ptr        <= 1'b0;
            tail_ptr        <= 1'b0;
            badUnit_o       <= 1'b0;
            dispatchCount_o <= '0;
            stallCount_o    <= '0;
        end else begin
            inflight <= readEnable_o;
            if (flush_i) begin
                occ      <= 2'd0;
                head_ptr <= 1'b0;
                tail_ptr <= 1'b0;
            end else begin
                if (inflight) tail_ptr <= ~tail_ptr;
                if (pop)      head_ptr <= ~head_ptr;
                occ <= occ + {1'b0, inflight} - {1'b0, pop};
            end
            if (pop && !fu_valid) badUnit_o <= 1'b1;
            if (transfer) dispatchCount_o <= dispatchCount_o + counterWidth'(1);
            if (stall)    stallCount_o    <= stallCount_o + counterWidth'(1);
        end
    end

    // Payload storage needs no reset; occupancy decides what is meaningful.
    always_ff @(posedge clock_i) begin
        if (inflight && !flush_i) begin
            buf_entry[tail_ptr] <= entry_i;
            buf_fu[tail_ptr]    <= funcUnitType_i;
        end
    end

endmodule

// File: tb/tb_ioq_dispatch_reader.sv
// Directed bench for ioq_dispatch_reader with a behavioural 1-cycle-latency queue on the read side.
module tb_ioq_dispatch_reader;

    localparam int EW = 299;
    localparam int FW = 3;
    localparam int NU = 8;
    localparam int CW = 32;

    logic          clock_i = 1'b0;
    logic          reset_i;
    logic          isEmpty_i;
    logic [FW-1:0] funcUnitType_i;
    logic [EW-1:0] entry_i;
    logic          readEnable_o;
    logic          flush_i;
    logic [NU-1:0] unitReady_i;
    logic [NU-1:0] dispatchValid_o;
    logic [EW-1:0] dispatchEntry_o;
    logic [FW-1:0] dispatchFU_o;
    logic [1:0]    occupancy_o;
    logic          badUnit_o;
    logic [CW-1:0] dispatchCount_o;
    logic [CW-1:0] stallCount_o;

    int checks = 0;
    int errors = 0;

    logic [FW-1:0] q_fu [$];
    logic [7:0]    q_id [$];
    logic [7:0]    log_id [$];
    logic          force_empty = 1'b0;
    logic          re_s;
    logic          re_prev = 1'b0;

    logic [31:0] t1_re  [7] = '{1, 1, 1, 1, 0, 0, 0};
    logic [31:0] t1_dv  [7] = '{0, 0, 'h80, 'h80, 'h80, 'h80, 0};
    logic [31:0] t1_occ [7] = '{0, 0, 1, 1, 1, 1, 0};
    logic [31:0] t2_re  [7] = '{1, 1, 0, 0, 0, 0, 1};
    logic [31:0] t2_occ [7] = '{0, 0, 1, 2, 2, 2, 2};
    logic [31:0] t2_st  [7] = '{0, 0, 0, 1, 2, 3, 4};
    logic [31:0] t3_dv  [6] = '{0, 0, 'h10, 0, 'h10, 0};
    logic [31:0] t3_bad [6] = '{0, 0, 0, 0, 1, 1};

    always #5 clock_i = ~clock_i;

    ioq_dispatch_reader dut (
        .clock_i         (clock_i),
        .reset_i         (reset_i),
        .isEmpty_i       (isEmpty_i),
        .funcUnitType_i  (funcUnitType_i),
        .entry_i         (entry_i),
        .readEnable_o    (readEnable_o),
        .flush_i         (flush_i),
        .unitReady_i     (unitReady_i),
        .dispatchValid_o (dispatchValid_o),
        .dispatchEntry_o (dispatchEntry_o),
        .dispatchFU_o    (dispatchFU_o),
        .occupancy_o     (occupancy_o),
        .badUnit_o       (badUnit_o),
        .dispatchCount_o (dispatchCount_o),
        .stallCount_o    (stallCount_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic upd_empty();
        isEmpty_i = force_empty || (q_fu.size() == 0);
    endtask

    task automatic load(input logic [FW-1:0] fu, input logic [7:0] id);
        q_fu.push_back(fu);
        q_id.push_back(id);
        upd_empty();
    endtask

    task automatic check_log(input string tag, input int n, input int first, input int stride);
        chk({tag, "_len"}, log_id.size(), n);
        for (int i = 0; i < n && i < log_id.size(); i++) begin
            chk(tag, log_id[i], first + i * stride);
        end
    endtask

    // One clock: sample at mid-cycle, then present queue read data 1 cycle after a read.
    task automatic step();
        #1;
        if (re_prev) begin
            checks++;
            assert (occupancy_o !== 2'd2) else begin
                errors++;
                $error("FAIL capture_at_full observed occupancy %0d expected below 2", occupancy_o);
            end
        end
        re_s = readEnable_o;
        if ((dispatchValid_o & unitReady_i) != '0) log_id.push_back(dispatchEntry_o[7:0]);
        @(posedge clock_i);
        #1;
        if (re_s && !reset_i) begin
            funcUnitType_i = q_fu.pop_front();
            entry_i        = '0;
            entry_i[7:0]   = q_id.pop_front();
        end
        re_prev = re_s && !reset_i;
        upd_empty();
        @(negedge clock_i);
    endtask

    initial begin
        reset_i = 1'b0;
        isEmpty_i = 1'b1;
        flush_i = 1'b0;
        unitReady_i = '1;
        funcUnitType_i = '0;
        entry_i = '0;
        #1 reset_i = 1'b1;
        #1;
        chk("rst_re", readEnable_o, 0);
        chk("rst_dv", dispatchValid_o, 0);
        chk("rst_occ", occupancy_o, 0);
        chk("rst_bad", badUnit_o, 0);
        chk("rst_dcnt", dispatchCount_o, 0);
        chk("rst_scnt", stallCount_o, 0);
        isEmpty_i = 1'b0;
        #1;
        chk("rst_re_nonempty", readEnable_o, 0);
        isEmpty_i = 1'b1;
        @(negedge clock_i);
        @(negedge clock_i);
        reset_i = 1'b0;

        // Streaming four fu=0 entries with all units ready
        log_id.delete();
        for (int i = 1; i <= 4; i++) load(3'd0, 8'(i));
        for (int k = 0; k < 7; k++) begin
            #1;
            chk("t1_re", readEnable_o, t1_re[k]);
            chk("t1_dv", dispatchValid_o, t1_dv[k]);
            chk("t1_occ", occupancy_o, t1_occ[k]);
            step();
        end
        chk("t1_dcnt", dispatchCount_o, 4);
        check_log("t1_order", 4, 1, 1);

        // Backpressure on unit 1
        log_id.delete();
        unitReady_i = 8'b10111111;
        for (int i = 11; i <= 16; i++) load(3'd1, 8'(i));
        for (int k = 0; k < 7; k++) begin
            if (k == 6) unitReady_i = '1;
            #1;
            chk("t2_re", readEnable_o, t2_re[k]);
            chk("t2_occ", occupancy_o, t2_occ[k]);
            chk("t2_stall", stallCount_o, t2_st[k]);
            if (k == 6) begin
                chk("t2_dv", dispatchValid_o, 'h40);
                chk("t2_fu", dispatchFU_o, 1);
            end
            step();
        end
        for (int k = 0; k < 8; k++) step();
        chk("t2_stall_final", stallCount_o, 4);
        chk("t2_dcnt", dispatchCount_o, 10);
        check_log("t2_order", 6, 11, 1);

        // Invalid unit code between two valid entries
        log_id.delete();
        load(3'd3, 8'd21);
        load(3'd5, 8'd22);
        load(3'd3, 8'd23);
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("t3_dv", dispatchValid_o, t3_dv[k]);
            chk("t3_bad", badUnit_o, t3_bad[k]);
            step();
        end
        chk("t3_dcnt", dispatchCount_o, 12);
        check_log("t3_order", 2, 21, 2);

        // Flush with one buffered entry and one in flight
        log_id.delete();
        for (int i = 31; i <= 33; i++) load(3'd0, 8'(i));
        #1;
        chk("t4_re0", readEnable_o, 1);
        step();
        #1;
        chk("t4_re1", readEnable_o, 1);
        chk("t4_occ1", occupancy_o, 0);
        step();
        flush_i = 1'b1;
        #1;
        chk("t4_re_flush", readEnable_o, 0);
        chk("t4_dv_flush", dispatchValid_o, 0);
        chk("t4_occ_flush", occupancy_o, 1);
        step();
        flush_i = 1'b0;
        #1;
        chk("t4_occ_after", occupancy_o, 0);
        chk("t4_re_resume", readEnable_o, 1);
        chk("t4_bad_kept", badUnit_o, 1);
        step();
        step();
        #1;
        chk("t4_dv_late", dispatchValid_o, 'h80);
        chk("t4_entry_late", dispatchEntry_o[7:0], 33);
        step();
        step();
        chk("t4_dcnt", dispatchCount_o, 13);
        check_log("t4_order", 1, 33, 1);

        // isEmpty_i toggling every cycle
        log_id.delete();
        for (int i = 41; i <= 46; i++) load(3'd4, 8'(i));
        for (int k = 0; k < 14; k++) begin
            force_empty = (k % 2 == 1);
            upd_empty();
            #1;
            chk("t5_re", readEnable_o, (k % 2 == 0 && k <= 10) ? 1 : 0);
            chk("t5_dv", dispatchValid_o, (k % 2 == 0 && k >= 2 && k <= 12) ? 'h08 : 0);
            step();
        end
        force_empty = 1'b0;
        upd_empty();
        chk("t5_dcnt", dispatchCount_o, 19);
        check_log("t5_order", 6, 41, 1);

        // Asynchronous reset mid-stream
        log_id.delete();
        for (int i = 51; i <= 54; i++) load(3'd6, 8'(i));
        step();
        step();
        #1;
        chk("t6_dv_pre", dispatchValid_o, 'h02);
        reset_i = 1'b1;
        #1;
        chk("t6_re", readEnable_o, 0);
        chk("t6_dv", dispatchValid_o, 0);
        chk("t6_occ", occupancy_o, 0);
        chk("t6_dcnt", dispatchCount_o, 0);
        chk("t6_scnt", stallCount_o, 0);
        chk("t6_bad", badUnit_o, 0);
        q_fu.delete();
        q_id.delete();
        upd_empty();
        log_id.delete();
        re_prev = 1'b0;
        step();
        step();
        reset_i = 1'b0;
        #1;
        chk("t6_occ_rel", occupancy_o, 0);
        chk("t6_dv_rel", dispatchValid_o, 0);
        step();
        step();
        check_log("t6_nothing", 0, 0, 1);
        load(3'd2, 8'd61);
        for (int k = 0; k < 4; k++) step();
        chk("t6_dcnt_after", dispatchCount_o, 1);
        check_log("t6_fresh", 1, 61, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
